// File: rtl/sp_sync_ram_be.sv
// sp_sync_ram_be: single-port synchronous RAM with per-byte write enables.
//
// - Registered read: one cycle of latency, marked by a one-cycle valid strobe.
// - Flags any access whose address is outside the implemented depth.
// - After every reset, an init sequencer writes zero to the whole memory.
//   The memory ignores all requests while that sequencer runs (busy = 1).
//
// Optional feature, enabled by defining SP_RAM_PARITY_EN:
//   - stores one even-parity bit per byte;
//   - checks every byte's parity on each read and reports it on parity_err.
// When SP_RAM_PARITY_EN is undefined, parity_err is tied to 0.
//
// Handshake: a request is the value of {cs, writeE, addr, be, data_K} sampled
// at a rising edge while busy = 0. There is no backpressure. Every accepted
// request completes at that edge. Read data, rd_valid, addr_err and parity_err
// become visible in the cycle that follows the sampling edge. They hold for
// that one cycle only. The exception is the data register, which keeps its
// value until the next read.

module sp_sync_ram_be #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cs,
    input  logic                    writeE,
    input  logic                    oe,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DATA_WIDTH-1:0]   data_K,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    rd_valid,
    output logic                    busy,
    output logic                    addr_err,
    output logic                    parity_err
);

    localparam int NB = DATA_WIDTH / 8;
    // Index width into the storage array; at least one bit even for DEPTH = 1.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0]         LAST_PTR = IW'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);

    // Reject parameter sets the storage layout cannot represent.
    generate
        if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
            $error("sp_sync_ram_be: DATA_WIDTH must be a non-zero multiple of 8");
        end
        if (DEPTH < 1 || DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
            $error("sp_sync_ram_be: DEPTH must be in 1 .. 2**ADDR_WIDTH");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   ptr_d;
    logic            busy_q;
    logic            busy_d;
    logic            init_we;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  in_range;
    logic [IW-1:0]         idx;
    logic                  req;
    logic                  wr_req;
    logic                  rd_req;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [DATA_WIDTH-1:0] data_q;
    logic                  rd_valid_q;
    logic                  addr_err_q;

    // Address decode.
    // Out-of-range addresses are steered to index 0, so the array is never
    // indexed past its end. in_range still blocks the access itself.
    always_comb begin
        in_range = ({1'b0, addr} < DEPTH_W);
        idx      = in_range ? addr[IW-1:0] : '0;
    end

    // Request qualification.
    // cs only counts in IDLE and outside reset.
    // Out-of-range writes are dropped here.
    always_comb begin
        req    = cs && (state_q == ST_IDLE) && !rst;
        wr_req = req && writeE && in_range;
        rd_req = req && !writeE;
    end

    // Out-of-range reads return zero rather than aliasing another word.
    always_comb begin
        rd_word = in_range ? mem[idx] : '0;
    end

    // Init sequencer: next state, next pointer, next busy and the init write strobe.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        init_we = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_we = 1'b1;
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    ptr_d   = ptr_q + IW'(1);
                    busy_d  = 1'b1;
                end
            end
            ST_IDLE: begin
                busy_d = 1'b0;
            end
            default: begin
                state_d = ST_INIT;
                ptr_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    // Sequencer state register.
    // Reset restarts initialisation from address 0, whatever the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    // Data storage.
    // Init writes zero to every word.
    // A normal write updates only the bytes whose enable bit is set.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[ptr_q] <= '0;
        end else if (wr_req) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= data_K[8*i +: 8];
                end
            end
        end
    end

    // Read register and pulse outputs.
    // The data register only changes on a read, so it holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q     <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_req;
            addr_err_q <= req && !in_range;
            if (rd_req) begin
                data_q <= rd_word;
            end
        end
    end

`ifdef SP_RAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic          par_mismatch;
    logic          parity_err_q;

    // Parity storage: one even-parity bit per byte.
    // The bits follow the same init and byte-enable pattern as the data.
    always_ff @(posedge clk) begin
        if (init_we) begin
            par_mem[ptr_q] <= '0;
        end else if (wr_req) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    par_mem[idx][i] <= ^data_K[8*i +: 8];
                end
            end
        end
    end

    // Recompute each byte's parity of the addressed word and compare it with
    // the stored bit.
    always_comb begin
        par_mismatch = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if ((^mem[idx][8*i +: 8]) != par_mem[idx][i]) begin
                par_mismatch = 1'b1;
            end
        end
    end

    // Parity error flag.
    // It lines up with rd_valid and is never set for an out-of-range read.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= rd_req && in_range && par_mismatch;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    // Output drive.
    // oe gates only the visible data. It does not affect the register or the strobes.
    always_comb begin
        data_out = oe ? data_q : '0;
        rd_valid = rd_valid_q;
        addr_err = addr_err_q;
        busy     = busy_q;
    end

endmodule

// File: tb/tb_sp_sync_ram_be.sv
// Directed testbench for sp_sync_ram_be.
// u_dut uses DEPTH 16. u_oor uses DEPTH 12 and covers the out-of-range
// addresses. Both instances share the same stimulus.
module tb_sp_sync_ram_be;

    logic        clk;
    logic        rst;
    logic        cs;
    logic        writeE;
    logic        oe;
    logic [3:0]  addr;
    logic [1:0]  be;
    logic [15:0] data_K;

    logic [15:0] data_out;
    logic        rd_valid;
    logic        busy;
    logic        addr_err;
    logic        parity_err;

    logic [15:0] oor_data_out;
    logic        oor_rd_valid;
    logic        oor_busy;
    logic        oor_addr_err;
    logic        oor_parity_err;

    int n_cmp = 0;
    int n_bad = 0;

    sp_sync_ram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(16)) u_dut (
        .clk(clk), .rst(rst), .cs(cs), .writeE(writeE), .oe(oe), .addr(addr),
        .be(be), .data_K(data_K), .data_out(data_out), .rd_valid(rd_valid),
        .busy(busy), .addr_err(addr_err), .parity_err(parity_err)
    );

    sp_sync_ram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(12)) u_oor (
        .clk(clk), .rst(rst), .cs(cs), .writeE(writeE), .oe(oe), .addr(addr),
        .be(be), .data_K(data_K), .data_out(oor_data_out), .rd_valid(oor_rd_valid),
        .busy(oor_busy), .addr_err(oor_addr_err), .parity_err(oor_parity_err)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Driver tasks: inputs change 1 ns after the rising edge, and outputs are
    // sampled at that same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        cs = 1'b0; writeE = 1'b0; addr = 4'd0; be = 2'b00; data_K = 16'h0000;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
        cs = 1'b1; writeE = 1'b1; addr = a; data_K = d; be = b;
        tick();
    endtask

    task automatic set_read(input logic [3:0] a);
        cs = 1'b1; writeE = 1'b0; addr = a; be = 2'b11; data_K = 16'hDEAD;
    endtask

    task automatic test_reset();
        int c16;
        int c12;
        int n;
        rst = 1'b1; drive_idle(); oe = 1'b1;
        tick(); tick();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy: got %b expected 1", busy); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rd_valid: got %b expected 0", rd_valid); end
        n_cmp++; if (addr_err !== 1'b0) begin n_bad++; $display("FAIL rst_addr_err: got %b expected 0", addr_err); end
        n_cmp++; if (data_out !== 16'h0000) begin n_bad++; $display("FAIL rst_data_out: got %h expected 0000", data_out); end
        n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL rst_parity_err: got %b expected 0", parity_err); end
        rst = 1'b0;
        c16 = 0; c12 = 0; n = 0;
        while ((busy === 1'b1 || oor_busy === 1'b1) && n < 100) begin
            if (busy === 1'b1) c16++;
            if (oor_busy === 1'b1) c12++;
            n++;
            tick();
        end
        n_cmp++; if (c16 != 16) begin n_bad++; $display("FAIL init_busy_len16: got %0d cycles expected 16", c16); end
        n_cmp++; if (c12 != 12) begin n_bad++; $display("FAIL init_busy_len12: got %0d cycles expected 12", c12); end
        for (int a = 0; a < 16; a++) begin
            set_read(4'(a));
            tick();
            n_cmp++;
            if (rd_valid !== 1'b1 || data_out !== 16'h0000) begin
                n_bad++;
                $display("FAIL init_read[%0d]: got data %h valid %b expected 0000 valid 1", a, data_out, rd_valid);
            end
        end
        drive_idle();
        tick();
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL init_read_end_valid: got %b expected 0", rd_valid); end
    endtask

    task automatic test_byte_enable();
        do_write(4'd3, 16'hABCD, 2'b11);
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL be_write_no_valid: got %b expected 0", rd_valid); end
        do_write(4'd3, 16'hFFFF, 2'b00);
        do_write(4'd3, 16'h1234, 2'b01);
        set_read(4'd3);
        tick();
        n_cmp++; if (data_out !== 16'hAB34) begin n_bad++; $display("FAIL be_merge_data: got %h expected AB34", data_out); end
        n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL be_merge_valid: got %b expected 1", rd_valid); end
        drive_idle();
        tick();
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL be_valid_one_cycle: got %b expected 0", rd_valid); end
        n_cmp++; if (data_out !== 16'hAB34) begin n_bad++; $display("FAIL be_data_hold: got %h expected AB34", data_out); end
    endtask

    task automatic test_oe_back_to_back();
        do_write(4'd1, 16'h5555, 2'b11);
        do_write(4'd2, 16'hAAAA, 2'b11);
        oe = 1'b1;
        set_read(4'd1); tick();
        n_cmp++; if (data_out !== 16'h5555 || rd_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_oe1_rd1: got %h/%b expected 5555/1", data_out, rd_valid); end
        set_read(4'd2); tick();
        n_cmp++; if (data_out !== 16'hAAAA || rd_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_oe1_rd2: got %h/%b expected AAAA/1", data_out, rd_valid); end
        drive_idle(); tick();
        n_cmp++; if (data_out !== 16'hAAAA || rd_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_oe1_idle: got %h/%b expected AAAA/0", data_out, rd_valid); end
        oe = 1'b0;
        set_read(4'd1); tick();
        n_cmp++; if (data_out !== 16'h0000 || rd_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_oe0_rd1: got %h/%b expected 0000/1", data_out, rd_valid); end
        set_read(4'd2); tick();
        n_cmp++; if (data_out !== 16'h0000 || rd_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_oe0_rd2: got %h/%b expected 0000/1", data_out, rd_valid); end
        drive_idle(); tick();
        oe = 1'b1; #1;
        n_cmp++; if (data_out !== 16'hAAAA || rd_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_oe_reenable: got %h/%b expected AAAA/0", data_out, rd_valid); end
    endtask

    task automatic test_out_of_range();
        logic [15:0] exp_d;
        do_write(4'd13, 16'hFFFF, 2'b11);
        n_cmp++; if (oor_addr_err !== 1'b1 || oor_rd_valid !== 1'b0) begin n_bad++; $display("FAIL oor_write_err: got err %b valid %b expected 1/0", oor_addr_err, oor_rd_valid); end
        n_cmp++; if (addr_err !== 1'b0) begin n_bad++; $display("FAIL inrange_write_err: got %b expected 0", addr_err); end
        drive_idle(); tick();
        n_cmp++; if (oor_addr_err !== 1'b0) begin n_bad++; $display("FAIL oor_err_one_cycle: got %b expected 0", oor_addr_err); end
        set_read(4'd13); tick();
        n_cmp++; if (oor_data_out !== 16'h0000 || oor_rd_valid !== 1'b1 || oor_addr_err !== 1'b1) begin
            n_bad++; $display("FAIL oor_read: got %h/%b/%b expected 0000/1/1", oor_data_out, oor_rd_valid, oor_addr_err);
        end
        n_cmp++; if (oor_parity_err !== 1'b0) begin n_bad++; $display("FAIL oor_read_parity: got %b expected 0", oor_parity_err); end
        n_cmp++; if (data_out !== 16'hFFFF || addr_err !== 1'b0) begin n_bad++; $display("FAIL inrange_read13: got %h/%b expected FFFF/0", data_out, addr_err); end
        for (int a = 0; a < 12; a++) begin
            case (a)
                1:       exp_d = 16'h5555;
                2:       exp_d = 16'hAAAA;
                3:       exp_d = 16'hAB34;
                default: exp_d = 16'h0000;
            endcase
            set_read(4'(a)); tick();
            n_cmp++;
            if (oor_data_out !== exp_d || oor_rd_valid !== 1'b1 || oor_addr_err !== 1'b0) begin
                n_bad++;
                $display("FAIL oor_keep[%0d]: got %h/%b/%b expected %h/1/0", a, oor_data_out, oor_rd_valid, oor_addr_err, exp_d);
            end
        end
        drive_idle(); tick();
    endtask

    task automatic test_busy_mid_init();
        int n;
        logic seen_pulse;
        rst = 1'b1; drive_idle(); tick();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL idle_rst_busy: got %b expected 1", busy); end
        rst = 1'b0;
        cs = 1'b1; writeE = 1'b1; addr = 4'd0; data_K = 16'hFFFF; be = 2'b11;
        for (int i = 0; i < 7; i++) tick();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL init_cycle7_busy: got %b expected 1", busy); end
        rst = 1'b1; tick(); rst = 1'b0;
        n = 0; seen_pulse = 1'b0;
        while (busy === 1'b1 && n < 100) begin
            if (rd_valid !== 1'b0 || addr_err !== 1'b0) seen_pulse = 1'b1;
            n++;
            tick();
        end
        drive_idle();
        n_cmp++; if (n != 16) begin n_bad++; $display("FAIL mid_init_busy_len: got %0d cycles expected 16", n); end
        n_cmp++; if (seen_pulse !== 1'b0) begin n_bad++; $display("FAIL busy_pulses: got %b expected 0", seen_pulse); end
        set_read(4'd0); tick();
        n_cmp++; if (data_out !== 16'h0000 || rd_valid !== 1'b1) begin n_bad++; $display("FAIL busy_write_dropped: got %h/%b expected 0000/1", data_out, rd_valid); end
        set_read(4'd3); tick();
        n_cmp++; if (data_out !== 16'h0000 || rd_valid !== 1'b1) begin n_bad++; $display("FAIL rezero_addr3: got %h/%b expected 0000/1", data_out, rd_valid); end
        set_read(4'd13); tick();
        n_cmp++; if (data_out !== 16'h0000 || rd_valid !== 1'b1) begin n_bad++; $display("FAIL rezero_addr13: got %h/%b expected 0000/1", data_out, rd_valid); end
        drive_idle(); tick();
    endtask

    task automatic test_parity();
        do_write(4'd5, 16'h00FF, 2'b11);
        drive_idle(); tick();
`ifdef SP_RAM_PARITY_EN
        u_dut.mem[5][0] = ~u_dut.mem[5][0];
        set_read(4'd5); tick();
        n_cmp++; if (parity_err !== 1'b1 || rd_valid !== 1'b1) begin n_bad++; $display("FAIL parity_detect: got err %b valid %b expected 1/1", parity_err, rd_valid); end
        n_cmp++; if (data_out !== 16'h00FE) begin n_bad++; $display("FAIL parity_data: got %h expected 00FE", data_out); end
`else
        set_read(4'd5); tick();
        n_cmp++; if (parity_err !== 1'b0 || rd_valid !== 1'b1) begin n_bad++; $display("FAIL parity_tied: got err %b valid %b expected 0/1", parity_err, rd_valid); end
        n_cmp++; if (data_out !== 16'h00FF) begin n_bad++; $display("FAIL parity_data: got %h expected 00FF", data_out); end
`endif
        set_read(4'd4); tick();
        n_cmp++; if (parity_err !== 1'b0 || rd_valid !== 1'b1 || data_out !== 16'h0000) begin
            n_bad++; $display("FAIL parity_clean: got err %b valid %b data %h expected 0/1/0000", parity_err, rd_valid, data_out);
        end
        drive_idle(); tick();
        n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL parity_one_cycle: got %b expected 0", parity_err); end
    endtask

    // Test sequence and final report
    initial begin
        rst = 1'b1; oe = 1'b1;
        drive_idle();
        test_reset();
        test_byte_enable();
        test_oe_back_to_back();
        test_out_of_range();
        test_busy_mid_init();
        test_parity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
